// File: rtl/bubble_drive8_top.sv
`default_nettype none
// ============================================================================
// Module : bubble_drive8_top
// Desc   : Bubble-memory cassette emulator core: shift timing, loop position,
//          page/bootloader requests, 2048x2 buffer and detector serialiser.
//          Define CLOCK_OUT_EN to drive clock_out with master_clock/2.
// Rev    : 1.0  initial release
// ============================================================================

module bubble_drive8_top #(
  parameter int CYCLE_CLKS = 480,
  parameter int OUT_START  = 300,
  parameter int OUT_WIDTH  = 64,
  parameter int LOOP_POS   = 2053,
  parameter int BOOT_BITS  = 1920,
  parameter int PAGE_BITS  = 584,
  parameter int PAGE_DELAY = 100
) (
  input  logic        master_clock,
  input  logic        power_good,
  output logic        clock_out,
  input  logic        bubble_shift_enable,
  input  logic        replicator_enable,
  input  logic        bootloop_enable,
  input  logic [2:0]  image_dip_switch,
  output logic        bubble_out_odd,
  output logic        bubble_out_even,
  output logic [21:0] start_of_page_address,
  input  logic [10:0] bubble_buffer_write_address,
  input  logic [1:0]  bubble_buffer_data_input,
  input  logic        bubble_buffer_write_enable,
  input  logic        bubble_buffer_write_clock,
  output logic        load_page,
  output logic        load_bootloader
);

  localparam logic [8:0]  c_cyc_last   = 9'(CYCLE_CLKS - 1);
  // Outputs are registered, so the window is evaluated one clock early.
  localparam logic [8:0]  c_win_first  = 9'(OUT_START - 1);
  localparam logic [8:0]  c_win_last   = 9'(OUT_START + OUT_WIDTH - 2);
  localparam logic [11:0] c_pos_last   = 12'(LOOP_POS - 1);
  localparam logic [10:0] c_boot_last  = 11'(BOOT_BITS - 1);
  localparam logic [10:0] c_page_last  = 11'(PAGE_BITS - 1);
  localparam logic [6:0]  c_delay_last = 7'(PAGE_DELAY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EMIT = 2'd2
  } emit_state_t;

  logic [2:0]  r_shift_s;
  logic [2:0]  r_repl_s;
  logic [1:0]  r_boot_s;
  logic [8:0]  r_cyc;
  logic [11:0] r_pos;
  logic [10:0] r_addr, w_addr_nx;
  logic [10:0] r_last, w_last_nx;
  logic [6:0]  r_delay, w_delay_nx;
  logic [21:0] r_sopa;
  logic        r_load_page, w_load_page_nx;
  logic        r_load_boot, w_load_boot_nx;
  logic        r_out_odd, r_out_even;
  logic [1:0]  r_rd_data;
  logic [1:0]  r_mem [0:2047];
  emit_state_t r_state, w_state_nx;

  logic w_shifting, w_shift_fall, w_repl_fall, w_wrap, w_pulse;

  assign w_shifting   = ~r_shift_s[1];
  assign w_shift_fall = r_shift_s[2] & ~r_shift_s[1];
  assign w_repl_fall  = r_repl_s[2] & ~r_repl_s[1];
  assign w_wrap       = w_shifting & (r_cyc == c_cyc_last);
  assign w_pulse      = (r_state == ST_EMIT) & w_shifting &
                        (r_cyc >= c_win_first) & (r_cyc <= c_win_last);

  always_ff @(posedge master_clock or negedge power_good) begin
    if (!power_good) begin
      r_shift_s <= 3'b111;
      r_repl_s  <= 3'b111;
      r_boot_s  <= 2'b11;
      r_cyc     <= '0;
      r_pos     <= '0;
    end else begin
      r_shift_s <= {r_shift_s[1:0], bubble_shift_enable};
      r_repl_s  <= {r_repl_s[1:0], replicator_enable};
      r_boot_s  <= {r_boot_s[0], bootloop_enable};
      if (!w_shifting || w_wrap) r_cyc <= '0;
      else                       r_cyc <= r_cyc + 9'd1;
      if (w_wrap) r_pos <= (r_pos == c_pos_last) ? 12'd0 : r_pos + 12'd1;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_addr_nx      = r_addr;
    w_last_nx      = r_last;
    w_delay_nx     = r_delay;
    w_load_page_nx = 1'b0;
    w_load_boot_nx = 1'b0;
    case (r_state)
      ST_WAIT: if (w_wrap) begin
        if (r_delay == c_delay_last) w_state_nx = ST_EMIT;
        else                         w_delay_nx = r_delay + 7'd1;
      end
      // Address saturates at the last bit and emission stops there.
      ST_EMIT: if (w_wrap) begin
        if (r_addr == r_last) w_state_nx = ST_IDLE;
        else                  w_addr_nx  = r_addr + 11'd1;
      end
      default: ;
    endcase
    if (w_shift_fall && !r_boot_s[1]) begin
      w_state_nx     = ST_EMIT;
      w_addr_nx      = '0;
      w_last_nx      = c_boot_last;
      w_load_boot_nx = 1'b1;
    end
    if (w_repl_fall && w_shifting) begin
      w_state_nx     = ST_WAIT;
      w_addr_nx      = '0;
      w_delay_nx     = '0;
      w_last_nx      = c_page_last;
      w_load_page_nx = 1'b1;
    end
  end

  always_ff @(posedge master_clock or negedge power_good) begin
    if (!power_good) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_last      <= '0;
      r_delay     <= '0;
      r_load_page <= 1'b0;
      r_load_boot <= 1'b0;
      r_sopa      <= '0;
      r_out_odd   <= 1'b1;
      r_out_even  <= 1'b1;
    end else begin
      r_state     <= w_state_nx;
      r_addr      <= w_addr_nx;
      r_last      <= w_last_nx;
      r_delay     <= w_delay_nx;
      r_load_page <= w_load_page_nx;
      r_load_boot <= w_load_boot_nx;
      if (w_load_page_nx) r_sopa <= {image_dip_switch, r_pos, 7'b0};
      r_out_odd   <= ~(w_pulse & r_rd_data[1]);
      r_out_even  <= ~(w_pulse & r_rd_data[0]);
    end
  end

  // Loader side and emitter side sit in different clock domains.
  always_ff @(posedge bubble_buffer_write_clock) begin
    if (!bubble_buffer_write_enable)
      r_mem[bubble_buffer_write_address] <= bubble_buffer_data_input;
  end

  always_ff @(posedge master_clock) begin
    r_rd_data <= r_mem[r_addr];
  end

`ifdef CLOCK_OUT_EN
  logic r_clk_div;
  always_ff @(posedge master_clock or negedge power_good) begin
    if (!power_good) r_clk_div <= 1'b0;
    else             r_clk_div <= ~r_clk_div;
  end
  assign clock_out = r_clk_div;
`else
  assign clock_out = 1'b0;
`endif

  assign bubble_out_odd        = r_out_odd;
  assign bubble_out_even       = r_out_even;
  assign start_of_page_address = r_sopa;
  assign load_page             = r_load_page;
  assign load_bootloader       = r_load_boot;

endmodule

`default_nettype wire

// File: tb/tb_bubble_drive8_top.sv
`default_nettype none
// ============================================================================
// Module : tb_bubble_drive8_top
// Desc   : Directed self-checking bench for bubble_drive8_top (shortened cycle).
// Rev    : 1.0  initial release
// ============================================================================

module tb_bubble_drive8_top;

  logic        clk = 1'b0;
  logic        power_good;
  logic        clock_out;
  logic        shift_n, repl_n, boot_n;
  logic [2:0]  dip;
  logic        out_odd, out_even;
  logic [21:0] sopa;
  logic [10:0] wa;
  logic [1:0]  wd;
  logic        we_n, wclk;
  logic        load_page, load_boot;

  int n_cmp = 0;
  int n_err = 0;
  int pe    = 0;

  localparam logic [15:0] P = 16'h1E00;  // clocks 9..12 of a 16-clock cycle

  bubble_drive8_top #(
    .CYCLE_CLKS (16),
    .OUT_START  (9),
    .OUT_WIDTH  (4),
    .LOOP_POS   (400),
    .BOOT_BITS  (1920),
    .PAGE_BITS  (584),
    .PAGE_DELAY (100)
  ) dut (
    .master_clock                (clk),
    .power_good                  (power_good),
    .clock_out                   (clock_out),
    .bubble_shift_enable         (shift_n),
    .replicator_enable           (repl_n),
    .bootloop_enable             (boot_n),
    .image_dip_switch            (dip),
    .bubble_out_odd              (out_odd),
    .bubble_out_even             (out_even),
    .start_of_page_address       (sopa),
    .bubble_buffer_write_address (wa),
    .bubble_buffer_data_input    (wd),
    .bubble_buffer_write_enable  (we_n),
    .bubble_buffer_write_clock   (wclk),
    .load_page                   (load_page),
    .load_bootloader             (load_boot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    pe++;
  endtask

  task automatic wait_to(input int n);
    while (pe < n) tick();
  endtask

  task automatic wbuf(input logic [10:0] a, input logic [1:0] d);
    wa = a; wd = d; we_n = 1'b0;
    #3 wclk = 1'b1;
    #3 wclk = 1'b0;
    we_n = 1'b1;
    #1;
  endtask

  task automatic rst_pulse();
    tick(); #1 power_good = 1'b0;
    tick(); tick(); #1 power_good = 1'b1;
    tick();
  endtask

  // Shift cycle c occupies posedges 2+16c .. 2+16c+15 after the drive edge.
  task automatic chk_cyc(input string tag, input int c, input logic [15:0] eo,
                         input logic [15:0] ee, input logic [15:0] eb);
    logic [15:0] mo, me, mb;
    mo = '0; me = '0; mb = '0;
    wait_to(2 + 16 * c - 1);
    for (int j = 0; j < 16; j++) begin
      tick(); #2;
      mo[j] = ~out_odd;
      me[j] = ~out_even;
      mb[j] = load_boot;
    end
    check({tag, "_odd"},  32'(mo), 32'(eo));
    check({tag, "_even"}, 32'(me), 32'(ee));
    check({tag, "_lboot"}, 32'(mb), 32'(eb));
  endtask

  task automatic start_shift();
    tick(); #1 shift_n = 1'b0;
    pe = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic flag;
    power_good = 1'b0; shift_n = 1'b1; repl_n = 1'b1; boot_n = 1'b1;
    dip = 3'b000; wa = '0; wd = '0; we_n = 1'b1; wclk = 1'b0;

    wbuf(11'd0, 2'b11);    wbuf(11'd1, 2'b10);
    wbuf(11'd2, 2'b01);    wbuf(11'd3, 2'b00);
    wbuf(11'd1417, 2'b11); wbuf(11'd1918, 2'b01);
    wbuf(11'd1919, 2'b00); wbuf(11'd1920, 2'b11);

    repeat (3) tick(); #2;
    check("rst_odd",   32'(out_odd),   32'd1);
    check("rst_even",  32'(out_even),  32'd1);
    check("rst_lboot", 32'(load_boot), 32'd0);
    check("rst_lpage", 32'(load_page), 32'd0);
    check("rst_addr",  32'(sopa),      32'd0);
    check("rst_clko",  32'(clock_out), 32'd0);
    #1 power_good = 1'b1;
    repeat (20) tick(); #2;
    check("idle_odd",   32'(out_odd),   32'd1);
    check("idle_even",  32'(out_even),  32'd1);
    check("idle_lboot", 32'(load_boot), 32'd0);
    check("idle_lpage", 32'(load_page), 32'd0);

    // Bootloader emission, including the last bits and saturation past the end
    boot_n = 1'b0;
    repeat (4) tick();
    start_shift();
    chk_cyc("boot_c0", 0, P, P, 16'h0002);
    chk_cyc("boot_c1", 1, P, 16'h0, 16'h0);
    chk_cyc("boot_c2", 2, 16'h0, P, 16'h0);
    chk_cyc("boot_c3", 3, 16'h0, 16'h0, 16'h0);
    chk_cyc("buf_1417", 1417, P, P, 16'h0);
    chk_cyc("buf_1918", 1918, 16'h0, P, 16'h0);
    chk_cyc("buf_1919", 1919, 16'h0, 16'h0, 16'h0);
    chk_cyc("sat_1920", 1920, 16'h0, 16'h0, 16'h0);
    chk_cyc("sat_1921", 1921, 16'h0, 16'h0, 16'h0);

    // Abort mid-pulse, then restart: cycle timing must begin from zero again
    tick(); #1 shift_n = 1'b1;
    repeat (6) tick(); #2;
    check("stop_odd",  32'(out_odd),  32'd1);
    check("stop_even", 32'(out_even), 32'd1);
    start_shift();
    wait_to(11); #2;
    check("abort_pre_odd", 32'(out_odd), 32'd0);
    shift_n = 1'b1;
    wait_to(14); #2;
    check("abort_odd",  32'(out_odd),  32'd1);
    check("abort_even", 32'(out_even), 32'd1);
    repeat (8) tick();
    start_shift();
    chk_cyc("restart_c0", 0, P, P, 16'h0002);

    // Page mode: replicate in cycle 385
    tick(); #1 shift_n = 1'b1;
    rst_pulse();
    boot_n = 1'b1;
    repeat (4) tick();
    start_shift();
    wait_to(2 + 385 * 16 + 3); #1 repl_n = 1'b0;
    wait_to(2 + 385 * 16 + 6); #2;
    check("page_lpage", 32'(load_page), 32'd1);
    check("page_addr",  32'(sopa),      32'h0000_C080);
    repl_n = 1'b1;
    tick(); #2;
    check("page_lpage_end", 32'(load_page), 32'd0);
    chk_cyc("page_c484", 484, 16'h0, 16'h0, 16'h0);
    chk_cyc("page_c485", 485, P, P, 16'h0);
    chk_cyc("page_c486", 486, P, 16'h0, 16'h0);

    // Replicate while not shifting must be ignored
    tick(); #1 shift_n = 1'b1;
    repeat (4) tick();
    #1 repl_n = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick(); #2;
      flag = flag | load_page;
      if (i == 6) repl_n = 1'b1;
    end
    check("norep_lpage", 32'(flag), 32'd0);
    check("norep_addr",  32'(sopa), 32'h0000_C080);

    // Loop wrap: 400 positions, replicate in cycle 405 -> page 5
    rst_pulse(); #2;
    check("rst2_addr", 32'(sopa), 32'd0);
    dip = 3'b101;
    start_shift();
    wait_to(2 + 405 * 16 + 3); #1 repl_n = 1'b0;
    wait_to(2 + 405 * 16 + 6); #2;
    check("wrap_lpage", 32'(load_page), 32'd1);
    check("wrap_addr",  32'(sopa),      32'h0028_0280);
    repl_n = 1'b1;
    tick(); #1 shift_n = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
